// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, LSB-first payload with checked stop bits.
// Bit timing is the same as uart_tx: one bit lasts CYCLES_PER_BIT+1 clk cycles.
module uart_rx #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic                    uart_rx_frame_err,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

  // state     | meaning
  // IDLE      | line idle, waiting for a start-bit low
  // START     | count to mid start bit, reject glitches
  // DATA      | sample payload bits at mid-bit
  // STOP      | sample and check each stop bit
  // WAIT_HIGH | after a framing error, wait for the line to return high

  localparam int BIT_P          = 1_000_000_000 / BIT_RATE;
  localparam int CLK_P          = 1_000_000_000 / CLK_HZ;
  localparam int CYCLES_PER_BIT = BIT_P / CLK_P;
  localparam int HALF           = CYCLES_PER_BIT / 2;
  localparam int CW             = 1 + $clog2(CYCLES_PER_BIT);
  localparam int IW             = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam int SW             = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [CW-1:0] CNT_BIT   = CW'(CYCLES_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF);
  localparam logic [IW-1:0] IDX_LAST  = IW'(PAYLOAD_BITS - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                  state, state_n;
  logic [1:0]              sync;
  logic                    rxd_s;
  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           bit_idx, bit_idx_n;
  logic [SW-1:0]           stop_idx, stop_idx_n;
  logic [PAYLOAD_BITS-1:0] shift, shift_n;
  logic [PAYLOAD_BITS-1:0] data_n;
  logic                    valid_n, ferr_n, brk_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], uart_rxd};
  end

  assign rxd_s = sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      bit_idx           <= '0;
      stop_idx          <= '0;
      shift             <= '0;
      uart_rx_data      <= '0;
      uart_rx_valid     <= 1'b0;
      uart_rx_frame_err <= 1'b0;
      uart_rx_break     <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      bit_idx           <= bit_idx_n;
      stop_idx          <= stop_idx_n;
      shift             <= shift_n;
      uart_rx_data      <= data_n;
      uart_rx_valid     <= valid_n;
      uart_rx_frame_err <= ferr_n;
      uart_rx_break     <= brk_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    stop_idx_n = stop_idx;
    shift_n    = shift;
    data_n     = uart_rx_data;
    valid_n    = 1'b0;
    ferr_n     = 1'b0;
    brk_n      = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (uart_rx_en && !rxd_s) state_n = START;
      end
      START: begin
        if (!uart_rx_en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_HALF) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rxd_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (!uart_rx_en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_BIT) begin
          cnt_n                   = '0;
          shift_n                 = shift >> 1;
          shift_n[PAYLOAD_BITS-1] = rxd_s;
          if (bit_idx == IDX_LAST) begin
            stop_idx_n = '0;
            state_n    = STOP;
          end else begin
            bit_idx_n = bit_idx + IW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (!uart_rx_en) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_BIT) begin
          cnt_n = '0;
          if (!rxd_s) begin
            ferr_n  = 1'b1;
            brk_n   = (shift == '0) && (stop_idx == '0);
            state_n = WAIT_HIGH;
          end else if (stop_idx == STOP_LAST) begin
            // Leave mid stop bit so a back-to-back start edge is not missed.
            data_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            stop_idx_n = stop_idx + SW'(1);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rxd_s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the companion to the existing uart_tx. It uses the same line format: 1 start bit, PAYLOAD_BITS data bits LSB-first, STOP_BITS stop bits, no parity. Bit timing is derived from the same BIT_RATE/CLK_HZ arithmetic as uart_tx, so paired instances interoperate exactly. It sits between the external RX pin and the core's byte-wide input path.

Parameters:
BIT_RATE, 9600, line bit rate in bits/s.
CLK_HZ, 50_000_000, clk frequency in Hz.
PAYLOAD_BITS, 8, data bits per frame.
STOP_BITS, 1, stop bits per frame; each one is checked.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
reset  input  1  asynchronous, active-high reset.
uart_rxd  input  1  serial line; asynchronous to clk; idles high.
uart_rx_en  input  1  receive enable.
uart_rx_break  output  1  1-cycle pulse: break detected (all data bits 0 and first stop bit 0).
uart_rx_valid  output  1  1-cycle pulse: uart_rx_data holds a newly received good frame.
uart_rx_frame_err  output  1  1-cycle pulse: a stop bit sampled 0.
uart_rx_data  output  PAYLOAD_BITS  last good payload; holds until the next valid pulse.

Behaviour:
- Timing constants:
  - BIT_P = 1_000_000_000/BIT_RATE and CLK_P = 1_000_000_000/CLK_HZ, both integer division.
  - CYCLES_PER_BIT = BIT_P/CLK_P.
  - One bit period is CYCLES_PER_BIT+1 clk cycles, matching uart_tx, whose counter runs 0..CYCLES_PER_BIT.
  - HALF = CYCLES_PER_BIT/2.
  - Counter width is 1+$clog2(CYCLES_PER_BIT).
- Synchronizer: uart_rxd passes through 2 flops, both reset to 1. rxd_s is the second flop output. All decisions use rxd_s only.
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - State = IDLE; counter = 0; bit index = 0; shift register = 0.
  - uart_rx_data = 0.
  - valid, frame_err and break = 0.
  - Synchronizer flops = 1.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: counter held at 0. If uart_rx_en=1 and rxd_s=0, go to START with counter=0.
  - START: counter increments each cycle.
    - At counter==HALF: if rxd_s=0, go to DATA with counter=0 and bit index=0.
    - If rxd_s=1 at that point: glitch; return to IDLE. No output pulse.
  - DATA: counter increments.
    - At counter==CYCLES_PER_BIT (mid-bit): shift rxd_s into the MSB of the shift register (right shift, LSB-first line order) and clear the counter.
    - After the PAYLOAD_BITS-th sample, go to STOP with stop index=0.
  - STOP: counter increments; at counter==CYCLES_PER_BIT, sample rxd_s.
    - Sample 1, not last stop bit: advance stop index, clear counter.
    - Sample 1, last stop bit:
      - uart_rx_data <= shift register.
      - uart_rx_valid=1 for exactly the next cycle.
      - Go to IDLE immediately (mid stop bit), so a back-to-back start bit is caught.
    - Sample 0:
      - uart_rx_frame_err=1 for one cycle.
      - Additionally uart_rx_break=1 in the same cycle if the shift register == 0 and this is the first stop bit.
      - uart_rx_data is unchanged.
      - Go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxd_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- uart_rx_en deasserted in START, DATA or STOP: abort to IDLE next cycle. No pulses; uart_rx_data unchanged.
- The valid, frame_err and break pulses are registered and are never asserted together with valid.
- Latency: the valid pulse is high in the cycle after the final stop-bit sample. That is 2 cycles (synchronizer) + HALF+1 + (PAYLOAD_BITS+STOP_BITS)*(CYCLES_PER_BIT+1) cycles after the start-bit falling edge on uart_rxd, plus or minus 1 cycle of edge phase.
- The block has no backpressure. A consumer that misses the valid pulse sees the data overwritten by the next good frame.

Test Plan:
All scenarios use CLK_HZ=1_000_000 and BIT_RATE=100_000, giving CYCLES_PER_BIT=10, an 11-cycle bit and HALF=5; uart_rx_en=1 unless stated.
- Loopback: uart_tx (same parameters) sends 0xA5, then 0x3C back-to-back -> two valid pulses, data 0xA5 then 0x3C; no frame_err or break.
- Glitch: drive uart_rxd low for 3 cycles, then high -> return to IDLE; no pulses; uart_rx_data still 0x00.
- Framing error: send 0x55 with the stop bit driven 0 for 11 cycles, then line high -> one frame_err pulse, no valid, data unchanged. The next frame, 0x81, is received correctly.
- Break: hold uart_rxd low for 30 bit times, then release -> exactly one cycle with break=1 and frame_err=1; no retrigger until the line is high; the next frame, 0x00 with a good stop bit, gives valid with data 0x00.
- Enable: drop uart_rx_en mid-data-bits of 0xFF -> no valid. Re-enable and send 0x12 -> valid with 0x12. With en=0 in IDLE, a full frame is ignored.
- Reset mid-frame: assert reset during bit 4 of 0xF0 -> outputs are 0 asynchronously. Release and send 0x0F -> valid with 0x0F; STOP_BITS=2 variant: second stop bit 0 -> frame_err.
